spiro_game_fsm: RTL and testbench

- Parametrised, multi-channel successor to the single-player spirometer game state machine.
- Runs CHANNELS independent player FSMs: IDLE -> ARMED -> RUN -> LOSE/WIN.
- Each channel has its own run-time score counter and a timeout that awards a win.
- A global arbiter latches the first winning channel for the display/Android link logic.

---
 rtl/spiro_game_fsm.sv | 132 +++++++++++++
 tb/tb_spiro_game_fsm.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/spiro_game_fsm.sv
// Multi-channel spirometer game controller: independent player FSMs with run-time
// scores, timeout wins, and a latch that keeps the first winning channel.
//
// state | meaning
// IDLE  | waiting for the player's start button
// ARMED | button seen, waiting for the LED countdown bar to empty
// RUN   | player blowing, score counts game ticks
// LOSE  | airflow dropped before timeout (absorbing)
// WIN   | survived TIMEOUT ticks (absorbing)
module spiro_game_fsm #(
    parameter int CHANNELS = 2,
    parameter int SCORE_W  = 12,
    parameter int TIMEOUT  = 1000,
    parameter int IDX_W    = 3
) (
    input  logic                        iClk,
    input  logic                        iReset,
    input  logic                        iCE,
    input  logic                        iClear,
    input  logic [CHANNELS-1:0]         ivBoton,
    input  logic [CHANNELS-1:0]         ivLEDEmpty,
    input  logic [CHANNELS-1:0]         ivLoser,
    output logic [3*CHANNELS-1:0]       ovState,
    output logic [SCORE_W*CHANNELS-1:0] ovScore,
    output logic                        oWinnerValid,
    output logic [IDX_W-1:0]            ovWinnerIdx,
    output logic                        oAllDone
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_RUN   = 3'd2,
        ST_LOSE  = 3'd3,
        ST_WIN   = 3'd4
    } state_e;

    localparam logic [SCORE_W-1:0] SCORE_LAST = SCORE_W'(TIMEOUT - 1);

    state_e             state_q [CHANNELS];
    state_e             state_d [CHANNELS];
    logic [SCORE_W-1:0] score_q [CHANNELS];
    logic [SCORE_W-1:0] score_d [CHANNELS];
    logic               winner_valid_q, winner_valid_d;
    logic [IDX_W-1:0]   winner_idx_q, winner_idx_d;
    logic               all_done_q, all_done_d;
    logic               win_seen;
    logic               done_all;

    always_comb begin
        state_d        = state_q;
        score_d        = score_q;
        winner_valid_d = winner_valid_q;
        winner_idx_d   = winner_idx_q;
        all_done_d     = all_done_q;
        win_seen       = 1'b0;
        done_all       = 1'b1;
        if (iClear) begin
            for (int k = 0; k < CHANNELS; k++) begin
                state_d[k] = ST_IDLE;
                score_d[k] = '0;
            end
            winner_valid_d = 1'b0;
            winner_idx_d   = '0;
            all_done_d     = 1'b0;
        end else if (iCE) begin
            for (int k = 0; k < CHANNELS; k++) begin
                case (state_q[k])
                    ST_IDLE:  if (ivBoton[k]) state_d[k] = ST_ARMED;
                    ST_ARMED: begin
                        if (ivLEDEmpty[k]) begin
                            state_d[k] = ST_RUN;
                            score_d[k] = '0;
                        end
                    end
                    ST_RUN: begin
                        if (ivLoser[k]) begin
                            state_d[k] = ST_LOSE;
                        end else begin
                            if (score_q[k] != '1) score_d[k] = score_q[k] + SCORE_W'(1);
                            if (score_q[k] == SCORE_LAST) begin
                                state_d[k] = ST_WIN;
                                // ascending loop: the first channel seen is the lowest index
                                if (!winner_valid_q && !win_seen) begin
                                    winner_valid_d = 1'b1;
                                    winner_idx_d   = IDX_W'(k);
                                end
                                win_seen = 1'b1;
                            end
                        end
                    end
                    ST_LOSE, ST_WIN: ;
                    default: state_d[k] = ST_IDLE;
                endcase
                if (!(state_d[k] == ST_LOSE || state_d[k] == ST_WIN)) done_all = 1'b0;
            end
            all_done_d = done_all;
        end
    end

    always_ff @(posedge iClk) begin
        if (!iReset) begin
            for (int k = 0; k < CHANNELS; k++) begin
                state_q[k] <= ST_IDLE;
                score_q[k] <= '0;
            end
            winner_valid_q <= 1'b0;
            winner_idx_q   <= '0;
            all_done_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            score_q        <= score_d;
            winner_valid_q <= winner_valid_d;
            winner_idx_q   <= winner_idx_d;
            all_done_q     <= all_done_d;
        end
    end

    always_comb begin
        ovState = '0;
        ovScore = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            ovState[3*k +: 3]             = state_q[k];
            ovScore[SCORE_W*k +: SCORE_W] = score_q[k];
        end
    end

    assign oWinnerValid = winner_valid_q;
    assign ovWinnerIdx  = winner_idx_q;
    assign oAllDone     = all_done_q;

endmodule

// File: tb/tb_spiro_game_fsm.sv
// Scoreboard bench for spiro_game_fsm: a driver applies stimulus and queues the
// model's expected outputs, a monitor pops and compares them after every edge.
module tb_spiro_game_fsm;

    localparam int CH = 2;
    localparam int SW = 12;
    localparam int TO = 10;
    localparam int IW = 3;

    typedef struct packed {
        logic [3*CH-1:0]  st;
        logic [SW*CH-1:0] sc;
        logic             wv;
        logic [IW-1:0]    wi;
        logic             done;
    } exp_t;

    logic             iClk = 1'b0;
    logic             iReset = 1'b0;
    logic             iCE = 1'b0;
    logic             iClear = 1'b0;
    logic [CH-1:0]    ivBoton = '0;
    logic [CH-1:0]    ivLEDEmpty = '0;
    logic [CH-1:0]    ivLoser = '0;
    logic [3*CH-1:0]  ovState;
    logic [SW*CH-1:0] ovScore;
    logic             oWinnerValid;
    logic [IW-1:0]    ovWinnerIdx;
    logic             oAllDone;

    spiro_game_fsm #(.CHANNELS(CH), .SCORE_W(SW), .TIMEOUT(TO), .IDX_W(IW)) dut (
        .iClk(iClk), .iReset(iReset), .iCE(iCE), .iClear(iClear),
        .ivBoton(ivBoton), .ivLEDEmpty(ivLEDEmpty), .ivLoser(ivLoser),
        .ovState(ovState), .ovScore(ovScore), .oWinnerValid(oWinnerValid),
        .ovWinnerIdx(ovWinnerIdx), .oAllDone(oAllDone)
    );

    always #5 iClk = ~iClk;

    // Reference model: game phase per player, ticks survived, first-winner latch.
    int   m_st [CH];
    int   m_sc [CH];
    bit   m_wv;
    int   m_wi;
    bit   m_done;
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic model_tick(input bit rst, input bit ce, input bit clr,
                              input logic [CH-1:0] b, input logic [CH-1:0] l,
                              input logic [CH-1:0] lo);
        int first;
        if (!rst || clr) begin
            for (int k = 0; k < CH; k++) begin m_st[k] = 0; m_sc[k] = 0; end
            m_wv = 0; m_wi = 0; m_done = 0;
        end else if (ce) begin
            first = -1;
            for (int k = 0; k < CH; k++) begin
                if (m_st[k] == 0) begin
                    if (b[k]) m_st[k] = 1;
                end else if (m_st[k] == 1) begin
                    if (l[k]) begin m_st[k] = 2; m_sc[k] = 0; end
                end else if (m_st[k] == 2) begin
                    if (lo[k]) m_st[k] = 3;
                    else begin
                        m_sc[k] = m_sc[k] + 1;
                        if (m_sc[k] == TO) begin
                            m_st[k] = 4;
                            if (first < 0) first = k;
                        end
                    end
                end
            end
            if (!m_wv && first >= 0) begin m_wv = 1; m_wi = first; end
            m_done = 1;
            for (int k = 0; k < CH; k++) if (m_st[k] < 3) m_done = 0;
        end
    endtask

    task automatic step(input bit rst, input bit ce, input bit clr,
                        input logic [CH-1:0] b, input logic [CH-1:0] l,
                        input logic [CH-1:0] lo);
        exp_t e;
        @(negedge iClk);
        iReset = rst; iCE = ce; iClear = clr;
        ivBoton = b; ivLEDEmpty = l; ivLoser = lo;
        model_tick(rst, ce, clr, b, l, lo);
        e = '0;
        for (int k = 0; k < CH; k++) begin
            e.st[3*k +: 3]   = 3'(m_st[k]);
            e.sc[SW*k +: SW] = SW'(m_sc[k]);
        end
        e.wv = m_wv;
        e.wi = IW'(m_wi);
        e.done = m_done;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge iClk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("state", 32'(ovState), 32'(e.st));
                check("score", 32'(ovScore), 32'(e.sc));
                check("winner_valid", 32'(oWinnerValid), 32'(e.wv));
                check("winner_idx", 32'(ovWinnerIdx), 32'(e.wi));
                check("all_done", 32'(oAllDone), 32'(e.done));
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        // reset held with every input high, then release
        step(0, 1, 1, '1, '1, '1);
        step(0, 1, 1, '1, '1, '1);
        step(1, 1, 0, 2'b11, 2'b00, 2'b00);

        // single-player lose after 5 RUN ticks
        step(1, 1, 1, '0, '0, '0);
        step(1, 1, 0, 2'b01, 2'b00, 2'b00);
        step(1, 1, 0, 2'b00, 2'b01, 2'b00);
        repeat (5) step(1, 1, 0, 2'b00, 2'b00, 2'b00);
        step(1, 1, 0, 2'b00, 2'b00, 2'b01);
        step(1, 1, 0, 2'b00, 2'b00, 2'b00);

        // ch1 timeout win
        step(1, 1, 1, '0, '0, '0);
        step(1, 1, 0, 2'b10, 2'b00, 2'b00);
        step(1, 1, 0, 2'b00, 2'b10, 2'b00);
        repeat (11) step(1, 1, 0, 2'b00, 2'b00, 2'b00);

        // simultaneous win on both channels
        step(1, 1, 1, '0, '0, '0);
        step(1, 1, 0, 2'b11, 2'b00, 2'b00);
        step(1, 1, 0, 2'b00, 2'b11, 2'b00);
        repeat (11) step(1, 1, 0, 2'b00, 2'b00, 2'b00);

        // loser on the tick that would reach TIMEOUT
        step(1, 1, 1, '0, '0, '0);
        step(1, 1, 0, 2'b01, 2'b00, 2'b00);
        step(1, 1, 0, 2'b00, 2'b01, 2'b00);
        repeat (TO - 1) step(1, 1, 0, 2'b00, 2'b00, 2'b00);
        step(1, 1, 0, 2'b00, 2'b00, 2'b01);
        step(1, 1, 0, 2'b00, 2'b00, 2'b00);

        // iCE gating in RUN, then clear mid-run with the button held
        step(1, 1, 1, '0, '0, '0);
        step(1, 1, 0, 2'b11, 2'b00, 2'b00);
        step(1, 1, 0, 2'b00, 2'b11, 2'b00);
        repeat (3) step(1, 1, 0, 2'b00, 2'b00, 2'b00);
        repeat (20) step(1, 0, 0, CH'($urandom), CH'($urandom), CH'($urandom));
        step(1, 0, 1, 2'b11, 2'b11, 2'b11);
        step(1, 1, 0, 2'b00, 2'b00, 2'b00);

        // randomized play
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 49) == 0),
                 CH'($urandom),
                 CH'($urandom),
                 {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)});
        end

        @(negedge iClk);
        @(negedge iClk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
